// File: rtl/tipi_link_master.sv
// TI-99 TIPI link master: shifts one byte to RD/RC or from TD/TC over r_clk/r_le/r_dout/r_din.
// Latency 21*HALF+1 (write) / 19*HALF+1 (read) busy cycles; req is ignored while busy, never queued.
module tipi_link_master #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic       wr,
  input  logic       cd,
  input  logic [0:7] wdata,
  output logic       busy,
  output logic       done,
  output logic [0:7] rdata,
  output logic       perr,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_dout,
  output logic       r_rt,
  output logic       r_cd,
  input  logic       r_din
);

  localparam int CW = $clog2(HALF);

  typedef enum logic [3:0] {
    S_IDLE, S_SETUP, S_LOAD, S_SHIFT_HI, S_SHIFT_LO,
    S_LATCH_HI, S_LATCH_LO, S_PAR_HI, S_PAR_LO, S_DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          wr_q;
  logic [0:7]    wdata_q;
  logic [0:7]    shreg;
  logic          par_s;
  logic          din_s1, din_s2;
  logic          last;

  assign last = (div_cnt == CW'(HALF - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      din_s1 <= 1'b0;
      din_s2 <= 1'b0;
    end else begin
      din_s1 <= r_din;
      din_s2 <= din_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      shreg   <= '0;
      par_s   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rdata   <= '0;
      perr    <= 1'b0;
      r_clk   <= 1'b0;
      r_le    <= 1'b0;
      r_dout  <= 1'b0;
      r_rt    <= 1'b0;
      r_cd    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state   <= S_SETUP;
            busy    <= 1'b1;
            wr_q    <= wr;
            wdata_q <= wdata;
            r_rt    <= ~wr;
            r_cd    <= cd;
            r_dout  <= wr ? wdata[0] : 1'b0;
            perr    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          div_cnt <= last ? '0 : div_cnt + CW'(1);
          // Link data is taken at the very end of the high phase, when it has settled longest.
          if (last && state == S_SHIFT_HI && !wr_q) shreg[bit_cnt] <= din_s2;
          if (last && state == S_PAR_HI) par_s <= din_s2;
          if (last) begin
            case (state)
              S_SETUP: begin
                if (wr_q) begin
                  state <= S_SHIFT_HI;
                  r_clk <= 1'b1;
                end else begin
                  state <= S_LOAD;
                  r_le  <= 1'b1;
                end
              end
              S_LOAD: begin
                state <= S_LATCH_LO;
                r_le  <= 1'b0;
              end
              S_SHIFT_HI: begin
                state <= S_SHIFT_LO;
                r_clk <= 1'b0;
                if (wr_q && bit_cnt != 3'd7) r_dout <= wdata_q[bit_cnt + 3'd1];
              end
              S_SHIFT_LO: begin
                if (bit_cnt == 3'd7) begin
                  if (wr_q) begin
                    state <= S_LATCH_HI;
                    r_le  <= 1'b1;
                  end else begin
                    state <= S_DONE;
                    done  <= 1'b1;
                    rdata <= shreg;
                  end
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  state   <= S_SHIFT_HI;
                  r_clk   <= 1'b1;
                end
              end
              S_LATCH_HI: begin
                state <= S_LATCH_LO;
                r_le  <= 1'b0;
              end
              S_LATCH_LO: begin
                state <= wr_q ? S_PAR_HI : S_SHIFT_HI;
                r_clk <= 1'b1;
              end
              S_PAR_HI: begin
                state <= S_PAR_LO;
                r_clk <= 1'b0;
              end
              S_PAR_LO: begin
                state <= S_DONE;
                done  <= 1'b1;
                perr  <= par_s ^ (^wdata_q);
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tipi_link_master.sv
// Directed bench for tipi_link_master: HALF=4 and HALF=2 instances sharing stimulus, selected by sel.
module tb_tipi_link_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, req, wr, cd, r_din, sel;
  logic [0:7] wdata;

  logic       busy4, done4, perr4, rclk4, rle4, rdout4, rrt4, rcd4;
  logic       busy2, done2, perr2, rclk2, rle2, rdout2, rrt2, rcd2;
  logic [0:7] rdata4, rdata2;

  tipi_link_master #(.HALF(4)) u_h4 (
    .clk(clk), .reset_n(reset_n), .req(req & ~sel), .wr(wr), .cd(cd), .wdata(wdata),
    .busy(busy4), .done(done4), .rdata(rdata4), .perr(perr4),
    .r_clk(rclk4), .r_le(rle4), .r_dout(rdout4), .r_rt(rrt4), .r_cd(rcd4), .r_din(r_din)
  );

  tipi_link_master #(.HALF(2)) u_h2 (
    .clk(clk), .reset_n(reset_n), .req(req & sel), .wr(wr), .cd(cd), .wdata(wdata),
    .busy(busy2), .done(done2), .rdata(rdata2), .perr(perr2),
    .r_clk(rclk2), .r_le(rle2), .r_dout(rdout2), .r_rt(rrt2), .r_cd(rcd2), .r_din(r_din)
  );

  logic       m_busy, m_done, m_perr, m_rclk, m_rle, m_rdout, m_rrt, m_rcd;
  logic [7:0] m_rdata;
  assign m_busy  = sel ? busy2  : busy4;
  assign m_done  = sel ? done2  : done4;
  assign m_perr  = sel ? perr2  : perr4;
  assign m_rclk  = sel ? rclk2  : rclk4;
  assign m_rle   = sel ? rle2   : rle4;
  assign m_rdout = sel ? rdout2 : rdout4;
  assign m_rrt   = sel ? rrt2   : rrt4;
  assign m_rcd   = sel ? rcd2   : rcd4;
  assign m_rdata = sel ? rdata2 : rdata4;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int         n_busy, n_clk, n_clk_pre, n_le, n_done, ovl, rt_bad, tx_cyc;
  logic       le_first, done_last, got_perr, perr_start;
  logic [7:0] sdout, got_rdata;

  // Runs one transaction and records what the link pins did; read data is presented
  // MSB-first, each bit after the falling edge of r_le (first) or r_clk (rest).
  task automatic run_txn(input logic w, input logic c, input logic [7:0] wd,
                         input logic echo, input logic [7:0] pat, input int pulse_at);
    logic pc, pl;
    int   bi;
    @(negedge clk);
    wr = w; cd = c; wdata = wd; r_din = w ? echo : 1'b0; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n_busy = 0; n_clk = 0; n_clk_pre = 0; n_le = 0; n_done = 0; ovl = 0; rt_bad = 0;
    le_first = 1'b0; done_last = 1'b0; sdout = '0; got_rdata = '0; got_perr = 1'b0;
    perr_start = 1'b0; pc = 1'b0; pl = 1'b0; bi = 0; tx_cyc = 0;
    while (m_busy && tx_cyc < 600) begin
      n_busy++;
      if (n_busy == 1) perr_start = m_perr;
      if (m_rrt !== ~w || m_rcd !== c) rt_bad++;
      if (m_rclk && m_rle) ovl++;
      if (m_rclk && !pc) begin
        n_clk++;
        if (n_le == 0) begin
          n_clk_pre++;
          sdout = {sdout[6:0], m_rdout};
        end
      end
      if (m_rle && !pl) begin
        n_le++;
        if (n_clk == 0) le_first = 1'b1;
      end
      if (!w && ((pl && !m_rle) || (pc && !m_rclk)) && bi < 8) begin
        r_din = pat[7 - bi];
        bi++;
      end
      done_last = m_done;
      if (m_done) begin
        n_done++;
        got_rdata = m_rdata;
        got_perr  = m_perr;
      end
      req = (n_busy == pulse_at);
      pc = m_rclk;
      pl = m_rle;
      @(negedge clk);
      tx_cyc++;
    end
    req = 1'b0;
    chk("txn_bounded", tx_cyc < 600, 1);
  endtask

  int   k, cyc, starts, idle_run, gap_bad, dn;
  logic pb, pc0;

  initial begin
    reset_n = 1'b0; req = 1'b0; wr = 1'b0; cd = 1'b0; wdata = '0; r_din = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pins_h4", {busy4, done4, perr4, rclk4, rle4, rdout4, rrt4, rcd4}, 0);
    chk("rst_rdata_h4", rdata4, 0);
    chk("rst_pins_h2", {busy2, done2, perr2, rclk2, rle2, rdout2, rrt2, rcd2}, 0);
    chk("rst_rdata_h2", rdata2, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // HALF=4 write A5, echo 0 -> no parity error; a req pulse mid-transfer must be dropped
    run_txn(1'b1, 1'b1, 8'hA5, 1'b0, 8'h00, 30);
    chk("w1_busy", n_busy, 85);
    chk("w1_sdout", sdout, 8'hA5);
    chk("w1_shift_clks", n_clk_pre, 8);
    chk("w1_all_clks", n_clk, 9);
    chk("w1_le", n_le, 1);
    chk("w1_done", {n_done[7:0], 7'b0, done_last}, {8'd1, 8'd1});
    chk("w1_perr", got_perr, 0);
    chk("w1_rt_cd", rt_bad, 0);
    chk("w1_overlap", ovl, 0);
    repeat (4) @(negedge clk);
    chk("w1_no_requeue", m_busy, 0);

    // Same write, echo 1 -> parity error flagged
    run_txn(1'b1, 1'b1, 8'hA5, 1'b1, 8'h00, 0);
    chk("w2_perr", got_perr, 1);
    chk("w2_busy", n_busy, 85);

    // HALF=4 read of 3C from TC; perr from previous write clears at accept
    run_txn(1'b0, 1'b0, 8'h00, 1'b0, 8'h3C, 0);
    chk("r1_perr_clear", perr_start, 0);
    chk("r1_busy", n_busy, 77);
    chk("r1_rdata", got_rdata, 8'h3C);
    chk("r1_perr", got_perr, 0);
    chk("r1_le_first", le_first, 1);
    chk("r1_clks", {n_clk[7:0], n_le[7:0]}, {8'd8, 8'd1});
    chk("r1_rt_cd", rt_bad, 0);
    chk("r1_overlap", ovl, 0);

    // A write leaves rdata untouched
    run_txn(1'b1, 1'b0, 8'h0F, 1'b0, 8'h00, 0);
    chk("w3_rdata_hold", got_rdata, 8'h3C);
    chk("w3_sdout", sdout, 8'h0F);

    // req held high: exactly three back-to-back transactions, one idle cycle apart
    @(negedge clk);
    wr = 1'b0; cd = 1'b1; r_din = 1'b0; req = 1'b1;
    dn = 0; starts = 0; idle_run = 0; gap_bad = 0; cyc = 0; pb = 1'b0;
    while (dn < 3 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (m_busy && !pb) begin
        starts++;
        if (starts > 1 && idle_run != 1) gap_bad++;
      end
      if (m_busy) idle_run = 0;
      else idle_run++;
      if (m_done) begin
        dn++;
        if (dn == 3) req = 1'b0;
      end
      pb = m_busy;
    end
    repeat (10) begin
      @(negedge clk);
      if (m_busy && !pb) starts++;
      pb = m_busy;
    end
    chk("b2b_bounded", cyc < 1000, 1);
    chk("b2b_starts", starts, 3);
    chk("b2b_gap", gap_bad, 0);

    // Reset during the fourth SHIFT_HI of a write
    @(negedge clk);
    wr = 1'b1; cd = 1'b1; wdata = 8'hA5; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    k = 0; cyc = 0; pc0 = 1'b0;
    while (k < 4 && cyc < 400) begin
      if (m_rclk && !pc0) k++;
      pc0 = m_rclk;
      if (k < 4) begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("rst_reach_hi4", k, 4);
    reset_n = 1'b0;
    #1;
    chk("rst_async", {m_rclk, m_rle, m_busy}, 0);
    dn = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    reset_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (m_done) dn++;
    end
    chk("rst_no_done", dn, 0);
    run_txn(1'b0, 1'b1, 8'h00, 1'b0, 8'h96, 0);
    chk("rst_read_rdata", got_rdata, 8'h96);
    chk("rst_read_busy", n_busy, 77);

    // HALF=2 write and read
    @(negedge clk);
    sel = 1'b1;
    run_txn(1'b1, 1'b1, 8'h3C, 1'b1, 8'h00, 0);
    chk("h2_w_busy", n_busy, 43);
    chk("h2_w_sdout", sdout, 8'h3C);
    chk("h2_w_perr", got_perr, 1);
    chk("h2_w_overlap", ovl, 0);
    run_txn(1'b0, 1'b0, 8'h00, 1'b0, 8'h5A, 0);
    chk("h2_r_busy", n_busy, 39);
    chk("h2_r_rdata", got_rdata, 8'h5A);
    chk("h2_r_perr", {got_perr, perr_start}, 0);
    chk("h2_r_le_first", le_first, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
